rk_kbd_matrix: RTL and testbench
================================

// Module: rk_kbd_matrix
// PURPOSE
//  Parametrised PS/2-to-key-matrix emulator; successor to the fixed 8x8 RK keyboard block.
//  Accepts raw PS/2 bytes and assembles the E0/F0/E1 prefixes itself.
//  Maps each code through an external keymap ROM, so one core serves RK86, Orion, Specialist and similar machines.
//  Sits between the PS/2 receiver (byte + strobe) and the machine's PPI port logic.
// PARAMETERS
//  NCOLS      8  matrix columns (scan/select lines driven by addr)
//  NROWS      8  matrix rows (read data width)
//  NMOD       3  modifier outputs (shift/ctrl/alt style)
//  ACTIVE_LOW 0  1: odata and mods inverted (pressed = 0)
//  Derived: CW=$clog2(NCOLS), RW=$clog2(NROWS), MDW=$clog2(NMOD+1), KW=1+MDW+CW+RW
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  ps2_data   in   8       received PS/2 byte
//  ps2_valid  in   1       1-cycle strobe, ps2_data valid
//  rom_addr   out  9       keymap address {ext, code}
//  rom_data   in   KW      {hit, modcode[MDW], col[CW], row[RW]}, valid 1 clk after rom_addr
//  addr       in   NCOLS   column select, one-hot or multi-hot
//  odata      out  NROWS   OR of selected columns
//  mods       out  NMOD    modifier states
//  any_key    out  1       any matrix bit set (uninverted)
//  drop       out  1       1-clk pulse: byte lost while busy
// BEHAVIOUR
//  Reset: matrix, mods and flags cleared; FSM in IDLE; rom_addr=0; drop=0.
//   odata = all-0, or all-1 when ACTIVE_LOW; mods likewise.
//  FSM states: IDLE, PFX, PAUSE, LOOK, APPLY.
//   IDLE/PFX, byte E0: ext<=1, go PFX.
//   IDLE/PFX, byte F0: brk<=1, go PFX.
//   IDLE, byte E1: load skip counter = 7, go PAUSE.
//    PAUSE counts down on each ps2_valid; back to IDLE at 0. Pause key produces no matrix event.
//   IDLE/PFX, byte AA, FC, 00 or FF: clear whole matrix and mods, clear ext/brk, go IDLE (hot-plug/error).
//   IDLE/PFX, any other byte: rom_addr <= {ext, byte}, go LOOK.
//   LOOK (1 clk, ROM latency): go APPLY.
//   APPLY: if hit, matrix[col][row] <= ~brk.
//    If modcode != 0, mods[modcode-1] <= ~brk (independent of hit).
//    Clear ext/brk, go IDLE.
//  Latency: final code byte strobe to matrix/mods update = 3 clk.
//   Next byte is accepted in the cycle after APPLY.
//  ps2_valid in LOOK or APPLY: byte discarded, drop pulses 1 clk, FSM unaffected.
//  Out-of-range ROM fields:
//   col >= NCOLS or row >= NROWS: entry treated as hit=0.
//   modcode > NMOD: modcode ignored.
//  Repeated make (typematic) is idempotent. Break of an unpressed key is harmless.
//  Two codes mapping to the same bit: last event wins; no reference counting.
//  Read side is combinational: odata = OR over i of (matrix[i] & {NROWS{addr[i]}}), then optional invert.
//   addr = 0 gives odata = 0 (all-1 when ACTIVE_LOW).
//  Reset asserted mid-sequence: prefix state is lost. A partial E0/F0 sequence after reset decodes as a plain code.
// STRUCTURE
//  Package rk_kbd_pkg: FSM state enum, constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PAUSE_LEN=7.
//   Package also holds the KW field-offset localparams.
//  Sub-module rk_kbd_prefix: prefix assembler FSM plus pause skip.
//   Outputs {ext, brk, code, code_valid, clear_all}.
//  Parent holds ROM interface, matrix registers, modifier registers and read mux.
//  Keymap ROM lives outside this block; one .mif per target machine.
// TESTING
//  1. Byte 1C, ROM[01C] = {1, 0, col2, row4} -> 3 clk later matrix[2][4] = 1; addr = 04 gives odata = 10.
//     Then F0,1C -> odata = 00.
//  2. E0,6B with ROM[16B] = {1, 0, 4, 1}, and 6B with ROM[06B] = {1, 0, 0, 7}:
//     -> extended press sets only [4][1]; plain press sets only [0][7].
//  3. 12 with ROM = {0, mod1, x, x} -> mods = 001. Then F0,12 -> mods = 000; matrix untouched.
//  4. E1,14,77,E1,F0,14,F0,77 -> no matrix/mod change; the following 1C is decoded normally.
//  5. Press 3 keys, then byte AA -> matrix and mods all 0, any_key = 0.
//     ps2_valid held in LOOK -> drop = 1 for 1 clk.
//  6. ACTIVE_LOW=1, NCOLS=11, NROWS=7:
//     reset -> odata = 7F; press at [10][6] with addr bit 10 set -> odata = 3F.
//     Assert reset mid-E0 -> everything cleared, FSM IDLE.

Source files
------------

// File: rtl/rk_kbd_pkg.sv
// Shared types and constants for the PS/2-to-key-matrix emulator.
// Keymap ROM word layout (LSB first): row, col, modcode, hit.
package rk_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PFX,
    ST_PAUSE,
    ST_LOOK,
    ST_APPLY
  } kbd_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] PS2_ERR   = 8'hFC;
  localparam logic [7:0] PS2_NUL   = 8'h00;
  localparam logic [7:0] PS2_OVF   = 8'hFF;

  localparam int PAUSE_LEN = 7;
  localparam int SKIP_W    = 3;

  localparam int ROW_LSB = 0;

  function automatic int col_lsb(input int rw);
    return rw;
  endfunction

  function automatic int mod_lsb(input int rw, input int cw);
    return rw + cw;
  endfunction

  function automatic int hit_bit(input int rw, input int cw, input int mdw);
    return rw + cw + mdw;
  endfunction

  // Keyboard self-test/error bytes that mean "forget every held key".
  function automatic logic is_clear_byte(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ERR) || (b == PS2_NUL) || (b == PS2_OVF);
  endfunction

endpackage

// File: rtl/rk_kbd_prefix.sv
// PS/2 prefix assembler: folds E0/F0 into flags, swallows the E1 pause
// sequence, and sequences the one-cycle keymap lookup.
module rk_kbd_prefix
  import rk_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_data,
  input  logic       ps2_valid,
  output logic       ext,
  output logic       brk,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       clear_all,
  output logic       drop
);

  kbd_state_e        state_q, state_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [7:0]        code_q, code_d;
  logic              code_ext_q, code_ext_d;
  logic              code_brk_q, code_brk_d;
  logic              drop_q;
  logic              busy;

  assign busy = (state_q == ST_LOOK) || (state_q == ST_APPLY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
      code_q     <= '0;
      code_ext_q <= 1'b0;
      code_brk_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      state_q    <= state_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
      code_q     <= code_d;
      code_ext_q <= code_ext_d;
      code_brk_q <= code_brk_d;
      drop_q     <= ps2_valid && busy;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d    = state_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    skip_d     = skip_q;
    code_d     = code_q;
    code_ext_d = code_ext_q;
    code_brk_d = code_brk_q;
    clear_all  = 1'b0;
    code_valid = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_PFX: begin
        if (ps2_valid) begin
          if (ps2_data == PS2_EXT) begin
            ext_d   = 1'b1;
            state_d = ST_PFX;
          end else if (ps2_data == PS2_BRK) begin
            brk_d   = 1'b1;
            state_d = ST_PFX;
          end else if ((ps2_data == PS2_PAUSE) && (state_q == ST_IDLE)) begin
            skip_d  = SKIP_W'(PAUSE_LEN);
            state_d = ST_PAUSE;
          end else if (is_clear_byte(ps2_data)) begin
            clear_all = 1'b1;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            code_d     = ps2_data;
            code_ext_d = ext_q;
            code_brk_d = brk_q;
            state_d    = ST_LOOK;
          end
        end
      end
      ST_PAUSE: begin
        if (ps2_valid) begin
          if (skip_q <= SKIP_W'(1)) begin
            skip_d  = '0;
            state_d = ST_IDLE;
          end else begin
            skip_d = skip_q - SKIP_W'(1);
          end
        end
      end
      ST_LOOK: begin
        state_d = ST_APPLY;
      end
      ST_APPLY: begin
        code_valid = 1'b1;
        ext_d      = 1'b0;
        brk_d      = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ext  = code_ext_q;
  assign brk  = code_brk_q;
  assign code = code_q;
  assign drop = drop_q;

endmodule

// File: rtl/rk_kbd_matrix.sv
// PS/2-to-key-matrix emulator: keymap ROM lookup, matrix and modifier
// registers, and the combinational column-select read mux.
module rk_kbd_matrix
  import rk_kbd_pkg::*;
#(
  parameter int  NCOLS      = 8,
  parameter int  NROWS      = 8,
  parameter int  NMOD       = 3,
  parameter bit  ACTIVE_LOW = 1'b0,
  localparam int CW         = $clog2(NCOLS),
  localparam int RW         = $clog2(NROWS),
  localparam int MDW        = $clog2(NMOD + 1),
  localparam int KW         = 1 + MDW + CW + RW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_valid,
  output logic [8:0]       rom_addr,
  input  logic [KW-1:0]    rom_data,
  input  logic [NCOLS-1:0] addr,
  output logic [NROWS-1:0] odata,
  output logic [NMOD-1:0]  mods,
  output logic             any_key,
  output logic             drop
);

  localparam int COL_LSB = col_lsb(RW);
  localparam int MOD_LSB = mod_lsb(RW, CW);
  localparam int HIT_BIT = hit_bit(RW, CW, MDW);

  logic             ext;
  logic             brk;
  logic [7:0]       code;
  logic             code_valid;
  logic             clear_all;

  logic             hit_f;
  logic [MDW-1:0]   mod_f;
  logic [CW-1:0]    col_f;
  logic [RW-1:0]    row_f;
  logic             key_hit;

  logic [NROWS-1:0] matrix [NCOLS];
  logic [NMOD-1:0]  mods_q;
  logic [NROWS-1:0] odata_raw;
  logic             any_raw;

  rk_kbd_prefix u_prefix (
    .clk        (clk),
    .reset      (reset),
    .ps2_data   (ps2_data),
    .ps2_valid  (ps2_valid),
    .ext        (ext),
    .brk        (brk),
    .code       (code),
    .code_valid (code_valid),
    .clear_all  (clear_all),
    .drop       (drop)
  );

  assign rom_addr = {ext, code};

  assign row_f = rom_data[ROW_LSB +: RW];
  assign col_f = rom_data[COL_LSB +: CW];
  assign mod_f = rom_data[MOD_LSB +: MDW];
  assign hit_f = rom_data[HIT_BIT];

  // Entries pointing outside the matrix are demoted to misses.
  assign key_hit = hit_f && (int'(col_f) < NCOLS) && (int'(row_f) < NROWS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the matrix is a small register array, not RAM, so it is
      // cleared by the async reset along with the rest of the state.
      for (int i = 0; i < NCOLS; i++) matrix[i] <= '0;
      mods_q <= '0;
    end else if (clear_all) begin
      for (int i = 0; i < NCOLS; i++) matrix[i] <= '0;
      mods_q <= '0;
    end else if (code_valid) begin
      for (int i = 0; i < NCOLS; i++) begin
        for (int j = 0; j < NROWS; j++) begin
          if (key_hit && (col_f == CW'(i)) && (row_f == RW'(j))) begin
            matrix[i][j] <= ~brk;
          end
        end
      end
      // Modcodes above NMOD match no slot and are thereby ignored.
      for (int k = 0; k < NMOD; k++) begin
        if (mod_f == MDW'(k + 1)) mods_q[k] <= ~brk;
      end
    end
  end

  always_comb begin
    odata_raw = '0;
    any_raw   = 1'b0;
    for (int i = 0; i < NCOLS; i++) begin
      odata_raw = odata_raw | (matrix[i] & {NROWS{addr[i]}});
      any_raw   = any_raw | (|matrix[i]);
    end
  end

  assign odata   = odata_raw ^ {NROWS{ACTIVE_LOW}};
  assign mods    = mods_q ^ {NMOD{ACTIVE_LOW}};
  assign any_key = any_raw;

endmodule

// File: tb/tb_rk_kbd_matrix.sv
// Directed bench for rk_kbd_matrix: default 8x8 instance driven from a vector
// table, plus an 11x7 active-low instance for inversion and reset corners.
module tb_rk_kbd_matrix;

  logic        clk = 1'b0;
  logic        reset;

  logic [7:0]  ps2_data_a, ps2_data_b;
  logic        ps2_valid_a, ps2_valid_b;
  logic [8:0]  rom_addr_a, rom_addr_b;
  logic [8:0]  rom_data_a;
  logic [9:0]  rom_data_b;
  logic [7:0]  addr_a;
  logic [10:0] addr_b;
  logic [7:0]  odata_a;
  logic [6:0]  odata_b;
  logic [2:0]  mods_a, mods_b;
  logic        any_a, any_b, drop_a, drop_b;

  logic [8:0]  rom_a [512];
  logic [9:0]  rom_b [512];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  rk_kbd_matrix u_dut_a (
    .clk(clk), .reset(reset), .ps2_data(ps2_data_a), .ps2_valid(ps2_valid_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .addr(addr_a),
    .odata(odata_a), .mods(mods_a), .any_key(any_a), .drop(drop_a)
  );

  rk_kbd_matrix #(.NCOLS(11), .NROWS(7), .NMOD(3), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .ps2_data(ps2_data_b), .ps2_valid(ps2_valid_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .addr(addr_b),
    .odata(odata_b), .mods(mods_b), .any_key(any_b), .drop(drop_b)
  );

  // Synchronous keymap ROMs: data valid one clock after the address.
  always @(posedge clk) begin
    rom_data_a <= rom_a[rom_addr_a];
    rom_data_b <= rom_b[rom_addr_b];
  end

  function automatic logic [8:0] enc_a(input logic h, input logic [1:0] m,
                                       input logic [2:0] c, input logic [2:0] r);
    return {h, m, c, r};
  endfunction

  function automatic logic [9:0] enc_b(input logic h, input logic [1:0] m,
                                       input logic [3:0] c, input logic [2:0] r);
    return {h, m, c, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    @(negedge clk);
    ps2_data_a  = b;
    ps2_valid_a = 1'b1;
    @(negedge clk);
    ps2_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    @(negedge clk);
    ps2_data_b  = b;
    ps2_valid_b = 1'b1;
    @(negedge clk);
    ps2_valid_b = 1'b0;
  endtask

  typedef struct {
    logic       snd;
    logic [7:0] b;
    int         idle;
    logic       chk;
    logic [7:0] addr;
    logic [7:0] odata;
    logic [2:0] mods;
    logic       any;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic snd, input logic [7:0] b, input int idle,
                     input logic chk, input logic [7:0] ad, input logic [7:0] od,
                     input logic [2:0] md, input logic an);
    vecs.push_back('{snd, b, idle, chk, ad, od, md, an, nm});
  endtask

  task automatic pfx(input logic [7:0] b);
    add("", 1'b1, b, 0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
  endtask

  vec_t v;
  int   drop_cnt;

  initial begin
    for (int i = 0; i < 512; i++) begin
      rom_a[i] = '0;
      rom_b[i] = '0;
    end
    rom_a[9'h01C] = enc_a(1'b1, 2'd0, 3'd2, 3'd4);
    rom_a[9'h16B] = enc_a(1'b1, 2'd0, 3'd4, 3'd1);
    rom_a[9'h06B] = enc_a(1'b1, 2'd0, 3'd0, 3'd7);
    rom_a[9'h012] = enc_a(1'b0, 2'd1, 3'd0, 3'd0);
    rom_a[9'h014] = enc_a(1'b1, 2'd0, 3'd1, 3'd1);
    rom_a[9'h077] = enc_a(1'b1, 2'd0, 3'd3, 3'd3);
    rom_a[9'h01B] = enc_a(1'b1, 2'd0, 3'd5, 3'd5);
    rom_a[9'h011] = enc_a(1'b1, 2'd2, 3'd7, 3'd7);
    rom_a[9'h02B] = enc_a(1'b1, 2'd0, 3'd2, 3'd4);
    rom_a[9'h059] = enc_a(1'b0, 2'd3, 3'd0, 3'd0);
    rom_a[9'h023] = enc_a(1'b1, 2'd0, 3'd6, 3'd0);
    rom_b[9'h01C] = enc_b(1'b1, 2'd0, 4'd10, 3'd6);
    rom_b[9'h015] = enc_b(1'b1, 2'd0, 4'd12, 3'd0);
    rom_b[9'h01A] = enc_b(1'b1, 2'd0, 4'd3, 3'd7);
    rom_b[9'h06B] = enc_b(1'b1, 2'd0, 4'd0, 3'd0);
    rom_b[9'h16B] = enc_b(1'b1, 2'd0, 4'd1, 3'd1);

    reset       = 1'b1;
    ps2_data_a  = '0;
    ps2_valid_a = 1'b0;
    ps2_data_b  = '0;
    ps2_valid_b = 1'b0;
    addr_a      = 8'hFF;
    addr_b      = 11'h7FF;
    repeat (2) @(negedge clk);

    check("rst_odata_a", 32'(odata_a), 32'h00);
    check("rst_mods_a", 32'(mods_a), 32'h0);
    check("rst_any_a", 32'(any_a), 32'h0);
    check("rst_drop_a", 32'(drop_a), 32'h0);
    check("rst_romaddr_a", 32'(rom_addr_a), 32'h0);
    check("rst_odata_b", 32'(odata_b), 32'h7F);
    check("rst_mods_b", 32'(mods_b), 32'h7);
    reset = 1'b0;

    // name, snd, byte, idle, chk, addr, odata, mods, any
    add("t1_make",        1, 8'h1C, 2, 1, 8'h04, 8'h10, 3'b000, 1);
    add("t1_other_col",   0, 8'h00, 0, 1, 8'h08, 8'h00, 3'b000, 1);
    pfx(8'hF0);
    add("t1_break",       1, 8'h1C, 2, 1, 8'h04, 8'h00, 3'b000, 0);
    pfx(8'hE0);
    add("t2_ext_make",    1, 8'h6B, 2, 1, 8'h10, 8'h02, 3'b000, 1);
    add("t2_ext_only",    0, 8'h00, 0, 1, 8'hFF, 8'h02, 3'b000, 1);
    pfx(8'hE0);
    pfx(8'hF0);
    add("t2_ext_break",   1, 8'h6B, 2, 1, 8'hFF, 8'h00, 3'b000, 0);
    add("t2_plain_make",  1, 8'h6B, 2, 1, 8'hFF, 8'h80, 3'b000, 1);
    add("t2_plain_only",  0, 8'h00, 0, 1, 8'h10, 8'h00, 3'b000, 1);
    add("t3_mod_make",    1, 8'h12, 2, 1, 8'hFF, 8'h80, 3'b001, 1);
    pfx(8'hF0);
    add("t3_mod_break",   1, 8'h12, 2, 1, 8'hFF, 8'h80, 3'b000, 1);
    pfx(8'hF0);
    add("t2_plain_brk",   1, 8'h6B, 2, 1, 8'hFF, 8'h00, 3'b000, 0);
    pfx(8'hE1); pfx(8'h14); pfx(8'h77); pfx(8'hE1);
    pfx(8'hF0); pfx(8'h14); pfx(8'hF0);
    add("t4_pause",       1, 8'h77, 2, 1, 8'hFF, 8'h00, 3'b000, 0);
    add("t4_after",       1, 8'h1C, 2, 1, 8'h04, 8'h10, 3'b000, 1);
    add("typematic",      1, 8'h1C, 2, 1, 8'hFF, 8'h10, 3'b000, 1);
    add("t5_key2",        1, 8'h1B, 2, 1, 8'h20, 8'h20, 3'b000, 1);
    add("t5_key3_mod",    1, 8'h11, 2, 1, 8'hFF, 8'hB0, 3'b010, 1);
    add("addr_zero",      0, 8'h00, 0, 1, 8'h00, 8'h00, 3'b010, 1);
    add("t5_clear_aa",    1, 8'hAA, 1, 1, 8'hFF, 8'h00, 3'b000, 0);
    add("fc_setup",       1, 8'h1C, 2, 1, 8'h04, 8'h10, 3'b000, 1);
    add("fc_clear",       1, 8'hFC, 1, 1, 8'hFF, 8'h00, 3'b000, 0);
    pfx(8'hF0);
    add("brk_unpressed",  1, 8'h1C, 2, 1, 8'hFF, 8'h00, 3'b000, 0);
    add("alias_make",     1, 8'h1C, 2, 1, 8'h04, 8'h10, 3'b000, 1);
    pfx(8'hF0);
    add("alias_last_win", 1, 8'h2B, 2, 1, 8'h04, 8'h00, 3'b000, 0);
    add("mod3",           1, 8'h59, 2, 1, 8'hFF, 8'h00, 3'b100, 0);
    add("clear_00",       1, 8'h00, 1, 1, 8'hFF, 8'h00, 3'b000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.snd) send_a(v.b);
      repeat (v.idle) @(negedge clk);
      if (v.chk) begin
        addr_a = v.addr;
        #1;
        check({v.name, "/odata"}, 32'(odata_a), 32'(v.odata));
        check({v.name, "/mods"}, 32'(mods_a), 32'(v.mods));
        check({v.name, "/any"}, 32'(any_a), 32'(v.any));
      end
    end

    // Latency: strobe on key 23 ([6][0]) lands exactly three edges later.
    addr_a = 8'h40;
    @(negedge clk);
    ps2_data_a  = 8'h23;
    ps2_valid_a = 1'b1;
    @(negedge clk);
    ps2_valid_a = 1'b0;
    check("lat_edge1", 32'(odata_a), 32'h00);
    @(negedge clk);
    check("lat_edge2", 32'(odata_a), 32'h00);
    @(negedge clk);
    check("lat_edge3", 32'(odata_a), 32'h01);

    // Byte arriving during LOOK is discarded and flagged for one cycle.
    addr_a = 8'hFF;
    @(negedge clk);
    ps2_data_a  = 8'h1C;
    ps2_valid_a = 1'b1;
    @(negedge clk);
    ps2_data_a  = 8'h1B;
    @(negedge clk);
    ps2_valid_a = 1'b0;
    drop_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (drop_a === 1'b1) drop_cnt++;
      @(negedge clk);
    end
    check("drop_width", 32'(drop_cnt), 32'd1);
    check("drop_no_effect", 32'(odata_a), 32'h11);

    // Active-low 11x7 instance.
    addr_b = 11'h7FF;
    send_b(8'h15);
    repeat (2) @(negedge clk);
    check("b_col_oor", 32'(odata_b), 32'h7F);
    send_b(8'h1A);
    repeat (2) @(negedge clk);
    check("b_row_oor", 32'(odata_b), 32'h7F);
    check("b_oor_any", 32'(any_b), 32'h0);
    send_b(8'h1C);
    repeat (2) @(negedge clk);
    addr_b = 11'h400;
    #1;
    check("b_press_10_6", 32'(odata_b), 32'h3F);
    check("b_any", 32'(any_b), 32'h1);
    addr_b = 11'h000;
    #1;
    check("b_addr_zero", 32'(odata_b), 32'h7F);

    send_b(8'hE0);
    reset = 1'b1;
    @(negedge clk);
    addr_b = 11'h7FF;
    #1;
    check("b_rst_odata", 32'(odata_b), 32'h7F);
    check("b_rst_any", 32'(any_b), 32'h0);
    check("b_rst_mods", 32'(mods_b), 32'h7);
    reset = 1'b0;
    send_b(8'h6B);
    repeat (2) @(negedge clk);
    addr_b = 11'h001;
    #1;
    check("b_plain_after_rst", 32'(odata_b), 32'h7E);
    addr_b = 11'h002;
    #1;
    check("b_no_ext_after_rst", 32'(odata_b), 32'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
